// File: rtl/memstage.sv
// memstage: MIPS memory-access stage with wait-state modelled data memory.
// Build option MEMSTAGE_WAITSTATE_EN: when defined, a wait-state FSM and
// counter stretch each memory access by WAIT cycles and raise stallM; when
// undefined, every access completes in its issue cycle and stallM is 0.
module memstage #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned WAIT  = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] aluoutM,
    input  logic [31:0] writedataM,
    input  logic [4:0]  writeregM,
    input  logic        zeroM,
    input  logic        branchM,
    input  logic        regwriteM,
    input  logic        memtoregM,
    input  logic        memwriteM,
    output logic        pcsrcM,
    output logic        stallM,
    output logic [31:0] readdataW,
    output logic [31:0] aluoutW,
    output logic [4:0]  writeregW,
    output logic        regwriteW,
    output logic        memtoregW
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] addr_c;
    logic          access_c;
    logic          stall_c;
    logic          unused_addr;

    // Word address; low byte-offset bits and upper bits wrap away
    assign addr_c      = aluoutM[AW+1:2];
    assign unused_addr = ^{aluoutM[31:AW+2], aluoutM[1:0]};
    assign access_c    = memtoregM | memwriteM;

`ifdef MEMSTAGE_WAITSTATE_EN
    typedef enum logic {IDLE, BUSY} state_e;

    state_e     state_q;
    logic [3:0] cnt_q;

    // Wait-state FSM: load WAIT-1 on a new access, count down, return to IDLE
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (access_c && (WAIT != 0)) begin
                        state_q <= BUSY;
                        cnt_q   <= 4'(WAIT - 1);
                    end
                end
                BUSY: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= 4'd0;
                end
            endcase
        end
    end

    // Stall while a fresh access needs wait states or the counter is running
    always_comb begin
        stall_c = 1'b0;
        case (state_q)
            IDLE:    stall_c = access_c && (WAIT != 0);
            BUSY:    stall_c = (cnt_q != 4'd0);
            default: stall_c = 1'b0;
        endcase
    end
`else
    logic unused_wait;

    assign stall_c     = 1'b0;
    assign unused_wait = |32'(WAIT);
`endif

    assign stallM = stall_c;
    assign pcsrcM = branchM & zeroM;

    // Data RAM: synchronous write only on the completing cycle of a store
    always_ff @(posedge clk) begin
        if (memwriteM && !stall_c) begin
            mem_q[addr_c] <= writedataM;
        end
    end

    // MEM/WB register: capture on completion, insert a bubble while stalled
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            readdataW <= 32'd0;
            aluoutW   <= 32'd0;
            writeregW <= 5'd0;
            regwriteW <= 1'b0;
            memtoregW <= 1'b0;
        end else if (stall_c) begin
            regwriteW <= 1'b0;
            memtoregW <= 1'b0;
        end else begin
            readdataW <= mem_q[addr_c];
            aluoutW   <= aluoutM;
            writeregW <= writeregM;
            regwriteW <= regwriteM;
            memtoregW <= memtoregM;
        end
    end

endmodule

// File: tb/tb_memstage.sv
// tb_memstage: directed vectors and reset corner cases for memstage.
module tb_memstage;

    localparam int unsigned DEPTH = 64;
    localparam int unsigned WAIT  = 2;
`ifdef MEMSTAGE_WAITSTATE_EN
    localparam int unsigned EW = WAIT;
`else
    localparam int unsigned EW = 0;
`endif
    localparam int unsigned MAXCYC = 40;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] aluoutM, writedataM;
    logic [4:0]  writeregM;
    logic        zeroM, branchM, regwriteM, memtoregM, memwriteM;
    logic        pcsrcM, stallM;
    logic [31:0] readdataW, aluoutW;
    logic [4:0]  writeregW;
    logic        regwriteW, memtoregW;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic        mw;
        logic        mr;
        logic        rw;
        logic        br;
        logic        zr;
        logic [31:0] alu;
        logic [31:0] wd;
        logic [4:0]  wr;
        logic        pcs;
        logic        chk_rd;
        logic [31:0] rd;
    } vec_t;

    memstage #(.DEPTH(DEPTH), .WAIT(WAIT)) dut (
        .clk(clk), .resetn(resetn),
        .aluoutM(aluoutM), .writedataM(writedataM), .writeregM(writeregM),
        .zeroM(zeroM), .branchM(branchM),
        .regwriteM(regwriteM), .memtoregM(memtoregM), .memwriteM(memwriteM),
        .pcsrcM(pcsrcM), .stallM(stallM),
        .readdataW(readdataW), .aluoutW(aluoutW), .writeregW(writeregW),
        .regwriteW(regwriteW), .memtoregW(memtoregW)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        aluoutM = 32'd0; writedataM = 32'd0; writeregM = 5'd0;
        zeroM = 1'b0; branchM = 1'b0;
        regwriteM = 1'b0; memtoregM = 1'b0; memwriteM = 1'b0;
    endtask

    function automatic vec_t mk(input logic mw, input logic mr, input logic rw,
                                input logic br, input logic zr,
                                input logic [31:0] alu, input logic [31:0] wd,
                                input logic [4:0] wr, input logic pcs,
                                input logic chk_rd, input logic [31:0] rd);
        vec_t v;
        v.mw = mw; v.mr = mr; v.rw = rw; v.br = br; v.zr = zr;
        v.alu = alu; v.wd = wd; v.wr = wr; v.pcs = pcs;
        v.chk_rd = chk_rd; v.rd = rd;
        return v;
    endfunction

    // Present one instruction (called at posedge+1), wait out stalls, check MEM/WB
    task automatic run_vec(input int idx, input vec_t v);
        int n;
        int exp_st;
        memwriteM = v.mw; memtoregM = v.mr; regwriteM = v.rw;
        branchM = v.br; zeroM = v.zr;
        aluoutM = v.alu; writedataM = v.wd; writeregM = v.wr;
        #1;
        chk($sformatf("v%0d_pcsrc", idx), 32'(pcsrcM), 32'(v.pcs));
        exp_st = (v.mw | v.mr) ? int'(EW) : 0;
        n = 0;
        while (stallM === 1'b1 && n < int'(MAXCYC)) begin
            @(posedge clk); #1;
            n++;
            chk($sformatf("v%0d_bubble_rw", idx), 32'(regwriteW), 32'd0);
            chk($sformatf("v%0d_bubble_mr", idx), 32'(memtoregW), 32'd0);
        end
        if (n >= int'(MAXCYC)) begin
            total++; bad++;
            $display("FAIL v%0d_timeout: stall still high after %0d cycles", idx, n);
        end
        chk($sformatf("v%0d_stall_cycles", idx), 32'(n), 32'(exp_st));
        @(posedge clk); #1;
        chk($sformatf("v%0d_aluoutW", idx), aluoutW, v.alu);
        chk($sformatf("v%0d_writeregW", idx), 32'(writeregW), 32'(v.wr));
        chk($sformatf("v%0d_regwriteW", idx), 32'(regwriteW), 32'(v.rw));
        chk($sformatf("v%0d_memtoregW", idx), 32'(memtoregW), 32'(v.mr));
        if (v.chk_rd) chk($sformatf("v%0d_readdataW", idx), readdataW, v.rd);
    endtask

    vec_t vecs[10];

    initial begin
        //               mw    mr    rw    br    zr    alu            wd             wr     pcs   chk   rd
        vecs[0] = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 5'd3,  1'b0, 1'b0, 32'h0);
        vecs[1] = mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0013, 32'h0,         5'd8,  1'b0, 1'b1, 32'hDEAD_BEEF);
        vecs[2] = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0104, 32'h1234_5678, 5'd0,  1'b0, 1'b0, 32'h0);
        vecs[3] = mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0004, 32'h0,         5'd12, 1'b0, 1'b1, 32'h1234_5678);
        vecs[4] = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0007, 32'h0,         5'd9,  1'b0, 1'b0, 32'h0);
        vecs[5] = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0000, 32'h0,         5'd0,  1'b1, 1'b0, 32'h0);
        vecs[6] = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0001, 32'h0,         5'd0,  1'b0, 1'b0, 32'h0);
        vecs[7] = mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0010, 32'h1111_1111, 5'd5,  1'b0, 1'b1, 32'hDEAD_BEEF);
        vecs[8] = mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0011, 32'h0,         5'd6,  1'b0, 1'b1, 32'h1111_1111);
        vecs[9] = mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0104, 32'h0,         5'd7,  1'b0, 1'b1, 32'h1234_5678);
    end

    initial begin
        bit  exp_written;
        resetn = 1'b0;
        idle_inputs();

        // Reset held for two cycles
        repeat (2) @(posedge clk);
        #1;
        chk("rst_readdataW", readdataW, 32'd0);
        chk("rst_aluoutW", aluoutW, 32'd0);
        chk("rst_writeregW", 32'(writeregW), 32'd0);
        chk("rst_regwriteW", 32'(regwriteW), 32'd0);
        chk("rst_memtoregW", 32'(memtoregW), 32'd0);
        chk("rst_stallM", 32'(stallM), 32'd0);
        resetn = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_stallM", 32'(stallM), 32'd0);

        for (int i = 0; i < 10; i++) begin
            run_vec(i, vecs[i]);
        end
        idle_inputs();
        @(posedge clk); #1;

        // Store to 0x20, then reset in its second cycle
        memwriteM = 1'b1; aluoutM = 32'h0000_0020; writedataM = 32'hCAFE_F00D;
        @(posedge clk); #1;
        resetn = 1'b0;
        idle_inputs();
        #1;
        chk("midrst_stallM", 32'(stallM), 32'd0);
        chk("midrst_regwriteW", 32'(regwriteW), 32'd0);
        chk("midrst_aluoutW", aluoutW, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        @(posedge clk); #1;
        chk("midrst_idle_stallM", 32'(stallM), 32'd0);

        // Only a single-cycle store can have landed before reset
        exp_written = (EW == 0);
        run_vec(10, mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0020, 32'h0, 5'd4,
                       1'b0, 1'b0, 32'h0));
        chk("midrst_store_landed", 32'(readdataW === 32'hCAFE_F00D), 32'(exp_written));

        idle_inputs();
        @(posedge clk); #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
